// File: rtl/yutorina_bus_slave_mem_if.sv
// Bus-slave signal bundle between a granted master and a memory slave.
// Active-low strobes/acknowledge keep the legacy naming of the original bus.
interface yutorina_bus_slave_mem_if #(
    parameter int unsigned WORD_ADDR_W = 30,
    parameter int unsigned WORD_DATA_W = 32
);
    logic                   cs_;
    logic                   as_;
    logic                   rw;
    logic [WORD_ADDR_W-1:0] addr;
    logic [WORD_DATA_W-1:0] w_data;
    logic [WORD_DATA_W-1:0] r_data;
    logic                   rdy_;

    modport master (
        output cs_, as_, rw, addr, w_data,
        input  r_data, rdy_
    );

    modport slave (
        input  cs_, as_, rw, addr, w_data,
        output r_data, rdy_
    );
endinterface

// File: rtl/yutorina_bus_slave_mem.sv
// Wait-state memory slave: latches a strobed access, waits WAIT cycles, then
// acknowledges for one cycle with read data (zero otherwise, for OR-combining).
module yutorina_bus_slave_mem #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT        = 2,
    parameter int unsigned WORD_DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    yutorina_bus_slave_mem_if.slave bus,
    output logic [15:0]             acc_cnt
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [WORD_DATA_W-1:0] mem [2**ADDR_W];

    logic [1:0]             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   rw_q, rw_d;
    logic [WORD_DATA_W-1:0] wdata_q, wdata_d;
    logic [WORD_DATA_W-1:0] r_data_q, r_data_d;
    logic                   rdy_q, rdy_d;
    logic [15:0]            acc_q, acc_d;

    logic                   strobe;
    logic [ADDR_W-1:0]      rd_addr;

    assign strobe = !bus.cs_ && !bus.as_;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    addr_d  = bus.addr[ADDR_W-1:0];
                    rw_d    = bus.rw;
                    wdata_d = bus.w_data;
                    cnt_d   = 4'(WAIT);
                    state_d = (WAIT == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.as_ || bus.cs_) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                acc_d   = acc_q + 16'd1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // With WAIT=0 the ACK is entered straight from IDLE, before addr_q holds the address.
    always_comb begin
        rd_addr  = (state_q == S_IDLE) ? bus.addr[ADDR_W-1:0] : addr_q;
        rdy_d    = (state_d != S_ACK);
        r_data_d = '0;
        if (state_d == S_ACK && rw_d) begin
            r_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b1;
            wdata_q  <= '0;
            r_data_q <= '0;
            rdy_q    <= 1'b1;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            wdata_q  <= wdata_d;
            r_data_q <= r_data_d;
            rdy_q    <= rdy_d;
            acc_q    <= acc_d;
        end
    end

    // Reset holds state in IDLE, so a reset mid-access can never commit a write.
    always_ff @(posedge clk) begin
        if (state_q == S_ACK && !rw_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.r_data = r_data_q;
    assign bus.rdy_   = rdy_q;
    assign acc_cnt    = acc_q;
endmodule
